// File: rtl/snake_body.sv
// rtl/snake_body.sv - one snake's body: head stepping, tail shift/grow, run/dead state
// Edge wrap-around is enabled by defining SNAKE_WRAP_EN; otherwise leaving the grid kills the snake.
module snake_body #(
  parameter int                 MAX_LEN   = 10,
  parameter int                 SEG_W     = 16,
  parameter int                 NUM_LEN   = 10,
  parameter logic [NUM_LEN-1:0] START_POS = 10'h210,
  parameter logic [1:0]         START_DIR = 2'd3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic                     tick_i,
  input  logic [1:0]               dir_req_i,
  input  logic                     grow_i,
  input  logic                     stop_i,
  output logic [MAX_LEN*SEG_W-1:0] snake_o,
  output logic [3:0]               length_o,
  output logic                     alive_o,
  output logic                     dead_o
);

  localparam int CW = NUM_LEN / 2;
  localparam logic [SEG_W-1:0] INIT_SEG = {1'b1, {(SEG_W-NUM_LEN-1){1'b0}}, START_POS};
  localparam logic [3:0] MAX_LEN_L = 4'(MAX_LEN);
  localparam logic [CW-1:0] EDGE_MAX = '1;

  typedef enum logic [1:0] {IDLE, RUN, DEAD} state_e;

  state_e           state_q, state_d;
  logic [SEG_W-1:0] body_q [MAX_LEN];
  logic [SEG_W-1:0] body_d [MAX_LEN];
  logic [3:0]       len_q, len_d;
  logic [1:0]       cdir_q, cdir_d;
  logic [1:0]       pend_q, pend_d;

  logic          accept;
  logic [1:0]    eff_dir;
  logic [CW-1:0] head_x, head_y, new_x, new_y;
  logic          edge_hit;
  logic          grow_ok;

  // A reversal of the committed heading is never latched; the last good request stands.
  assign accept  = (dir_req_i != (cdir_q ^ 2'd1));
  assign eff_dir = accept ? dir_req_i : pend_q;
  assign head_x  = body_q[0][CW-1:0];
  assign head_y  = body_q[0][NUM_LEN-1:CW];
  assign grow_ok = grow_i && (len_q < MAX_LEN_L);

  always_comb begin
    new_x = head_x;
    new_y = head_y;
    case (eff_dir)
      2'd0:    new_y = head_y - 1'b1;
      2'd1:    new_y = head_y + 1'b1;
      2'd2:    new_x = head_x - 1'b1;
      default: new_x = head_x + 1'b1;
    endcase
  end

`ifdef SNAKE_WRAP_EN
  assign edge_hit = 1'b0;
`else
  assign edge_hit = ((eff_dir == 2'd0) && (head_y == '0))       ||
                    ((eff_dir == 2'd1) && (head_y == EDGE_MAX)) ||
                    ((eff_dir == 2'd2) && (head_x == '0))       ||
                    ((eff_dir == 2'd3) && (head_x == EDGE_MAX));
`endif

  always_comb begin
    state_d = state_q;
    body_d  = body_q;
    len_d   = len_q;
    cdir_d  = cdir_q;
    pend_d  = pend_q;
    case (state_q)
      IDLE: begin
        if (accept) pend_d = dir_req_i;
        if (start_i) state_d = RUN;
      end
      RUN: begin
        if (accept) pend_d = dir_req_i;
        if (stop_i) begin
          state_d = DEAD;
        end else if (tick_i) begin
          if (edge_hit) begin
            state_d = DEAD;
          end else begin
            body_d[0] = {1'b1, {(SEG_W-NUM_LEN-1){1'b0}}, new_y, new_x};
            // Slots past the live length are zero, so only live slots (plus the grown one) shift.
            for (int i = 1; i < MAX_LEN; i++) begin
              if ((4'(i) < len_q) || ((4'(i) == len_q) && grow_ok))
                body_d[i] = body_q[i-1];
            end
            len_d  = len_q + {3'b000, grow_ok};
            cdir_d = eff_dir;
            pend_d = eff_dir;
          end
        end
      end
      DEAD: begin
        if (start_i) begin
          state_d = RUN;
          for (int i = 0; i < MAX_LEN; i++) body_d[i] = '0;
          body_d[0] = INIT_SEG;
          len_d     = 4'd1;
          cdir_d    = START_DIR;
          pend_d    = START_DIR;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      for (int i = 0; i < MAX_LEN; i++) body_q[i] <= '0;
      body_q[0] <= INIT_SEG;
      len_q     <= 4'd1;
      cdir_q    <= START_DIR;
      pend_q    <= START_DIR;
    end else begin
      state_q <= state_d;
      for (int i = 0; i < MAX_LEN; i++) body_q[i] <= body_d[i];
      len_q   <= len_d;
      cdir_q  <= cdir_d;
      pend_q  <= pend_d;
    end
  end

  for (genvar g = 0; g < MAX_LEN; g++) begin : g_pack
    assign snake_o[g*SEG_W +: SEG_W] = body_q[g];
  end

  assign length_o = len_q;
  assign alive_o  = (state_q == RUN);
  assign dead_o   = (state_q == DEAD);

endmodule
